// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Two-port arbiter in front of a single-port, synchronous-read
//                data RAM. Port 0 is the CPU, port 1 a debug/DMA loader.
//                Accesses are serialised through IDLE -> ACCESS (-> RWAIT for
//                reads), and read data is returned only to the winning port.
//                Round-robin on contention by default; define
//                MEM_ARB_CPU_PRIO_EN to give port 0 fixed priority instead.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_arbiter #(
    parameter int AW = 9,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          reset,
    // port 0 (CPU)
    input  logic          p0_req,
    input  logic          p0_write,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    output logic          p0_gnt,
    output logic          p0_rvalid,
    output logic [DW-1:0] p0_rdata,
    // port 1 (debug / DMA loader)
    input  logic          p1_req,
    input  logic          p1_write,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_gnt,
    output logic          p1_rvalid,
    output logic [DW-1:0] p1_rdata,
    // RAM side
    output logic [AW-1:0] ram_addr,
    output logic          ram_write,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout,
    // status
    output logic          busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RWAIT  = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;

    logic           r_winner;       // 0 = port 0 owns the current access
    logic           r_write;        // current access is a write
    logic           r_last_winner;  // reset to 1 so port 0 wins the first tie
    logic           r_ram_write;
    logic [AW-1:0]  r_ram_addr;
    logic [DW-1:0]  r_ram_din;
    logic [DW-1:0]  r_p0_rdata;
    logic [DW-1:0]  r_p1_rdata;
    logic           r_p0_rvalid;
    logic           r_p1_rvalid;

    logic           w_any_req;
    logic           w_pick;         // port that wins if a request is taken
    logic           w_take;         // accept a request this cycle
    logic           w_p0_gnt;
    logic           w_p1_gnt;

    // Choose which port would win if a request were accepted now
    always_comb begin
        w_any_req = p0_req | p1_req;
`ifdef MEM_ARB_CPU_PRIO_EN
        // Port 0 always wins; port 1 only when port 0 is not asking.
        w_pick    = ~p0_req;
`else
        // On a tie the port that did not win last time goes next.
        if (p0_req && p1_req) begin
            w_pick = ~r_last_winner;
        end else begin
            w_pick = ~p0_req;
        end
`endif
    end

    // Next-state logic and grant decode
    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        w_p0_gnt    = 1'b0;
        w_p1_gnt    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_take      = 1'b1;
                    w_state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                w_p0_gnt    = ~r_winner;
                w_p1_gnt    = r_winner;
                w_state_nxt = r_write ? ST_IDLE : ST_RWAIT;
            end
            ST_RWAIT: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Access latch, RAM strobe sequencing and read-data return
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_winner      <= 1'b0;
            r_write       <= 1'b0;
            r_last_winner <= 1'b1;
            r_ram_write   <= 1'b0;
            r_ram_addr    <= '0;
            r_ram_din     <= '0;
            r_p0_rdata    <= '0;
            r_p1_rdata    <= '0;
            r_p0_rvalid   <= 1'b0;
            r_p1_rvalid   <= 1'b0;
        end else begin
            r_p0_rvalid <= 1'b0;
            r_p1_rvalid <= 1'b0;

            if (w_take) begin
                r_winner      <= w_pick;
                r_last_winner <= w_pick;
                r_write       <= w_pick ? p1_write : p0_write;
                r_ram_write   <= w_pick ? p1_write : p0_write;
                r_ram_addr    <= w_pick ? p1_addr  : p0_addr;
                r_ram_din     <= w_pick ? p1_wdata : p0_wdata;
            end

            // The write commits on the edge that ends ACCESS; drop the strobe there.
            if (r_state == ST_ACCESS) begin
                r_ram_write <= 1'b0;
            end

            // RAM output is valid during RWAIT; hand it to the winner only.
            if (r_state == ST_RWAIT) begin
                if (r_winner) begin
                    r_p1_rdata  <= ram_dout;
                    r_p1_rvalid <= 1'b1;
                end else begin
                    r_p0_rdata  <= ram_dout;
                    r_p0_rvalid <= 1'b1;
                end
            end
        end
    end

    assign p0_gnt    = w_p0_gnt;
    assign p1_gnt    = w_p1_gnt;
    assign p0_rvalid = r_p0_rvalid;
    assign p1_rvalid = r_p1_rvalid;
    assign p0_rdata  = r_p0_rdata;
    assign p1_rdata  = r_p1_rdata;
    assign ram_addr  = r_ram_addr;
    assign ram_write = r_ram_write;
    assign ram_din   = r_ram_din;
    assign busy      = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Directed self-checking bench for mem_arbiter with a
//                behavioural synchronous-read RAM. Inputs change and outputs
//                are sampled on the falling clock edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int AW = 9;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          p0_req, p0_write;
    logic [AW-1:0] p0_addr;
    logic [DW-1:0] p0_wdata;
    logic          p0_gnt, p0_rvalid;
    logic [DW-1:0] p0_rdata;
    logic          p1_req, p1_write;
    logic [AW-1:0] p1_addr;
    logic [DW-1:0] p1_wdata;
    logic          p1_gnt, p1_rvalid;
    logic [DW-1:0] p1_rdata;
    logic [AW-1:0] ram_addr;
    logic          ram_write;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;
    logic          busy;

    int n_pass = 0;
    int n_chk  = 0;

    mem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_write(p0_write), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_write(p1_write), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .ram_addr(ram_addr), .ram_write(ram_write), .ram_din(ram_din),
        .ram_dout(ram_dout), .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural single-port RAM: write on the edge, read data one cycle later
    logic [DW-1:0] mem [0:511];
    logic          init_mem;
    always @(posedge clk) begin
        if (init_mem) begin
            mem[8] <= 16'hB081;
        end else begin
            if (ram_write) mem[ram_addr] <= ram_din;
            ram_dout <= mem[ram_addr];
        end
    end

    task automatic test_reset;
        reset = 1'b1; init_mem = 1'b1;
        p0_req = 0; p0_write = 0; p0_addr = '0; p0_wdata = '0;
        p1_req = 0; p1_write = 0; p1_addr = '0; p1_wdata = '0;
        @(negedge clk); @(negedge clk);
        init_mem = 1'b0;
        n_chk++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
        n_chk++; if ({p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, ram_write} !== 5'b0)
            $display("FAIL rst_strobes: got %b want 00000", {p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, ram_write}); else n_pass++;
        n_chk++; if ({ram_addr, ram_din, p0_rdata, p1_rdata} !== '0)
            $display("FAIL rst_data: addr %h din %h r0 %h r1 %h want 0", ram_addr, ram_din, p0_rdata, p1_rdata); else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_single_read;
        p0_req = 1; p0_write = 0; p0_addr = 9'h008;           // C0
        @(negedge clk);                                       // C1
        n_chk++; if ({p0_gnt, p1_gnt, busy} !== 3'b101) $display("FAIL rd_gnt: got %b want 101", {p0_gnt, p1_gnt, busy}); else n_pass++;
        n_chk++; if (ram_addr !== 9'h008) $display("FAIL rd_addr: got %h want 008", ram_addr); else n_pass++;
        p0_req = 0;
        @(negedge clk);                                       // C2
        n_chk++; if ({p0_gnt, p0_rvalid, busy} !== 3'b001) $display("FAIL rd_rwait: got %b want 001", {p0_gnt, p0_rvalid, busy}); else n_pass++;
        @(negedge clk);                                       // C3
        n_chk++; if ({p0_rvalid, busy} !== 2'b10) $display("FAIL rd_rvalid: got %b want 10", {p0_rvalid, busy}); else n_pass++;
        n_chk++; if (p0_rdata !== 16'hB081) $display("FAIL rd_data: got %h want b081", p0_rdata); else n_pass++;
        n_chk++; if ({p1_gnt, p1_rvalid, p1_rdata} !== '0) $display("FAIL rd_p1_quiet: got %b %b %h want 0", p1_gnt, p1_rvalid, p1_rdata); else n_pass++;
        @(negedge clk);
        n_chk++; if (p0_rvalid !== 1'b0) $display("FAIL rd_rvalid_pulse: got %b want 0", p0_rvalid); else n_pass++;
    endtask

    task automatic test_write_then_read;
        p1_req = 1; p1_write = 1; p1_addr = 9'h002; p1_wdata = 16'h000A;
        @(negedge clk);                                       // p1 ACCESS
        n_chk++; if ({p1_gnt, p0_gnt, ram_write} !== 3'b101) $display("FAIL wr_gnt: got %b want 101", {p1_gnt, p0_gnt, ram_write}); else n_pass++;
        n_chk++; if ({ram_addr, ram_din} !== {9'h002, 16'h000A}) $display("FAIL wr_bus: got %h/%h want 002/000a", ram_addr, ram_din); else n_pass++;
        p1_req = 0; p1_write = 0;
        @(negedge clk);                                       // IDLE
        n_chk++; if ({ram_write, busy} !== 2'b00) $display("FAIL wr_done: got %b want 00", {ram_write, busy}); else n_pass++;
        n_chk++; if (mem[2] !== 16'h000A) $display("FAIL wr_mem: got %h want 000a", mem[2]); else n_pass++;
        p0_req = 1; p0_write = 0; p0_addr = 9'h002;
        @(negedge clk);
        n_chk++; if ({p0_gnt, ram_write} !== 2'b10) $display("FAIL wr_rd_gnt: got %b want 10", {p0_gnt, ram_write}); else n_pass++;
        p0_req = 0;
        @(negedge clk);
        n_chk++; if (ram_write !== 1'b0) $display("FAIL wr_rd_strobe: got %b want 0", ram_write); else n_pass++;
        @(negedge clk);
        n_chk++; if ({p0_rvalid, p0_rdata} !== {1'b1, 16'h000A}) $display("FAIL wr_rd_data: got %b/%h want 1/000a", p0_rvalid, p0_rdata); else n_pass++;
        n_chk++; if (p1_rvalid !== 1'b0) $display("FAIL wr_rd_p1: got %b want 0", p1_rvalid); else n_pass++;
    endtask

    // Reset first so the very first tie goes to port 0, then keep both busy
    task automatic test_contention;
        int gport [0:7];
        int g = 0;
        int last_g = -1;
        int exp_port;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        p0_req = 1; p0_write = 0; p0_addr = 9'h008;
        p1_req = 1; p1_write = 0; p1_addr = 9'h002;
        for (int cyc = 1; cyc <= 18; cyc++) begin
            @(negedge clk);
            if (p0_gnt && p1_gnt) begin
                n_chk++; $display("FAIL cont_dual_gnt: got 11 want one-hot at cycle %0d", cyc);
            end
            if (p0_gnt || p1_gnt) begin
                last_g = p1_gnt ? 1 : 0;
                if (g < 8) gport[g] = last_g;
                g++;
            end
            if (p0_rvalid) begin
                n_chk++; if (last_g !== 0 || p0_rdata !== 16'hB081) $display("FAIL cont_rv0: owner %0d data %h want 0/b081", last_g, p0_rdata); else n_pass++;
            end
            if (p1_rvalid) begin
                n_chk++; if (last_g !== 1 || p1_rdata !== 16'h000A) $display("FAIL cont_rv1: owner %0d data %h want 1/000a", last_g, p1_rdata); else n_pass++;
            end
            if (cyc == 18) begin p0_req = 0; p1_req = 0; end
        end
        n_chk++; if (g !== 6) $display("FAIL cont_count: got %0d want 6", g); else n_pass++;
        for (int k = 0; k < 6; k++) begin
`ifdef MEM_ARB_CPU_PRIO_EN
            exp_port = 0;
`else
            exp_port = k % 2;
`endif
            if (k < g) begin
                n_chk++; if (gport[k] !== exp_port) $display("FAIL cont_order[%0d]: got %0d want %0d", k, gport[k], exp_port); else n_pass++;
            end
        end
        @(negedge clk); @(negedge clk);
        n_chk++; if (busy !== 1'b0) $display("FAIL cont_idle: got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_reset_rwait;
        p1_req = 1; p1_write = 0; p1_addr = 9'h008;
        @(negedge clk);
        n_chk++; if (p1_gnt !== 1'b1) $display("FAIL rr_gnt: got %b want 1", p1_gnt); else n_pass++;
        p1_req = 0;
        @(negedge clk);                                       // RWAIT
        reset = 1'b1;
        #1;
        n_chk++; if ({busy, p1_rvalid, p1_rdata} !== '0) $display("FAIL rr_abort: busy %b rv %b data %h want 0", busy, p1_rvalid, p1_rdata); else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_chk++; if ({busy, p1_rvalid} !== 2'b00) $display("FAIL rr_no_rvalid: got %b want 00", {busy, p1_rvalid}); else n_pass++;
        p1_req = 1;
        @(negedge clk);
        n_chk++; if (p1_gnt !== 1'b1) $display("FAIL rr_regnt: got %b want 1", p1_gnt); else n_pass++;
        p1_req = 0;
        @(negedge clk); @(negedge clk);
        n_chk++; if ({p1_rvalid, p1_rdata} !== {1'b1, 16'hB081}) $display("FAIL rr_redata: got %b/%h want 1/b081", p1_rvalid, p1_rdata); else n_pass++;
    endtask

    task automatic test_back_to_back;
        int gcyc [0:3];
        int k = 0;
        p0_req = 1; p0_write = 1; p0_addr = 9'h010; p0_wdata = 16'd1;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(negedge clk);
            if (p0_gnt) begin
                if (k < 4) begin
                    gcyc[k] = cyc;
                    n_chk++; if ({ram_write, ram_addr, ram_din} !== {1'b1, 9'(9'h010 + k), 16'(k + 1)})
                        $display("FAIL b2b_bus[%0d]: got %b/%h/%h", k, ram_write, ram_addr, ram_din); else n_pass++;
                end
                k++;
                if (k >= 4) begin
                    p0_req = 0; p0_write = 0;
                end else begin
                    p0_addr = 9'(9'h010 + k); p0_wdata = 16'(k + 1);
                end
            end
        end
        n_chk++; if (k !== 4) $display("FAIL b2b_count: got %0d want 4", k); else n_pass++;
        n_chk++; if (k > 0 && gcyc[0] !== 1) $display("FAIL b2b_first: got cycle %0d want 1", gcyc[0]); else n_pass++;
        for (int i = 1; i < 4; i++) begin
            if (i < k) begin
                n_chk++; if (gcyc[i] - gcyc[i-1] !== 2) $display("FAIL b2b_gap[%0d]: got %0d want 2", i, gcyc[i] - gcyc[i-1]); else n_pass++;
            end
        end
        n_chk++; if ({mem[9'h010], mem[9'h011], mem[9'h012], mem[9'h013]} !== {16'd1, 16'd2, 16'd3, 16'd4})
            $display("FAIL b2b_mem: got %h %h %h %h want 1 2 3 4", mem[9'h010], mem[9'h011], mem[9'h012], mem[9'h013]); else n_pass++;
    endtask

    initial begin
        test_reset;
        test_single_read;
        test_write_then_read;
        test_contention;
        test_reset_rwait;
        test_back_to_back;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port arbiter that shares the single-port, synchronous-read data memory between the CPU (port 0) and a secondary requester (port 1, a debug/DMA loader).
- Sits between the CPU memory interface and the RAM instance in the top level.
- Serialises accesses, sequences RAM timing (write strobe, read wait) and returns read data to the winner.
- Round-robin fairness by default; fixed CPU priority optional.

Parameters:
- AW, 9, address width of ports and RAM.
- DW, 16, data width.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- p0_req  input  1  port 0 request; held with p0_write/p0_addr/p0_wdata stable until p0_gnt
- p0_write  input  1  1 = write, 0 = read
- p0_addr  input  AW  port 0 address
- p0_wdata  input  DW  port 0 write data
- p0_gnt  output  1  one-cycle pulse: port 0 request accepted (ACCESS cycle)
- p0_rvalid  output  1  one-cycle pulse: p0_rdata updated by a completed read
- p0_rdata  output  DW  last read data for port 0, held between reads
- p1_req, p1_write, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_rdata: same as port 0, for port 1
- ram_addr  output  AW  RAM address
- ram_write  output  1  RAM write enable; RAM writes on the rising edge ending the cycle
- ram_din  output  DW  RAM write data
- ram_dout  input  DW  RAM read data, valid the cycle after the address is presented
- busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (async, active-high) values:
  - State = IDLE.
  - All gnt, rvalid, ram_write and busy = 0.
  - ram_addr, ram_din, p0_rdata and p1_rdata = 0.
  - last_winner = 1, so port 0 wins the first tie.
- Reset mid-operation:
  - Any in-flight access is abandoned with no rvalid.
  - An aborted write either did not occur or completed; no partial write is possible because ram_write is registered.
- FSM states: IDLE, ACCESS, RWAIT.
- IDLE:
  - Samples requests on each rising edge.
  - Neither requesting: stay in IDLE.
  - Exactly one requesting: that port wins.
  - Both requesting: the port != last_winner wins.
  - On a win: latch winner, write bit, addr and wdata into registers driving ram_addr/ram_din; ram_write = write bit; go to ACCESS; last_winner updated.
- ACCESS (one cycle):
  - pN_gnt = 1 for the winner only.
  - ram_write held for writes; the write commits at the edge ending ACCESS.
  - Next state: write goes to IDLE; read goes to RWAIT.
  - ram_write is deasserted at the edge leaving ACCESS.
- RWAIT (one cycle):
  - ram_dout is valid during this cycle.
  - At the edge ending RWAIT: capture ram_dout into the winner's pN_rdata, set the winner's pN_rvalid for exactly one cycle, go to IDLE.
- rvalid and the next IDLE cycle coincide. A new request may be sampled at the end of that cycle.
- Latency, with req high in cycle C0:
  - Write: gnt in C1; memory updated at the end of C1; 2 cycles minimum per write.
  - Read: gnt in C1; rvalid and rdata in C3; 3 cycles minimum per read.
- Requester rules:
  - Must keep req and its qualifiers stable until gnt.
  - req still high in the cycle after gnt is a new request.
  - Changing qualifiers before gnt is illegal; the arbiter uses values sampled at the winning edge.
- The losing requester sees no gnt and remains pending. Under continuous contention, grants strictly alternate 0,1,0,1.
- The non-winner's rdata never changes.
- ram_addr/ram_din hold their last values when idle.
- No address checking: full AW passed through; out-of-range handling belongs to the RAM.

Optional Feature:
- Macro: MEM_ARB_CPU_PRIO_EN.
- Defined: fixed priority. Port 0 always wins simultaneous requests; port 1 is served only when p0_req = 0 in IDLE. last_winner is still tracked but ignored.
- Undefined: round-robin as above.

Test Plan:
- Reset then single port-0 read of addr 9'h008 (RAM preloaded 16'hB081) -> p0_gnt in C1, p0_rvalid in C3 with p0_rdata = 16'hB081, p1 outputs stay 0.
- Port-1 write addr 9'h002 data 16'h000A, then port-0 read of 9'h002 -> ram_write high only in port-1 ACCESS cycle; p0_rdata = 16'h000A.
- Both ports hold read requests continuously for 6 grants -> grant order 0,1,0,1,0,1; each rvalid goes only to its own port. With MEM_ARB_CPU_PRIO_EN, port 0 gets all grants while p0_req stays high.
- Both request in the same IDLE cycle immediately after reset -> port 0 granted first, port 1 granted in the next ACCESS.
- Assert reset during RWAIT of a port-1 read -> state IDLE, busy = 0, no p1_rvalid, p1_rdata = 0. Next port-1 request completes normally.
- Back-to-back port-0 writes to 9'h010..9'h013 (data 1..4) with req held high -> 4 gnt pulses spaced 2 cycles apart; RAM contents match.
